// File: rtl/ram1_bus_ctrl.sv
// ============================================================================
// Module      : ram1_bus_ctrl
// Description : Two-port arbiter/sequencer for the shared RAM1 SRAM/UART bus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram1_bus_ctrl #(
    parameter logic [15:0] UART_DATA_ADDR = 16'hBF00,
    parameter logic [15:0] UART_STAT_ADDR = 16'hBF01,
    parameter logic [7:0]  TX_TIMEOUT     = 8'd255
) (
    input  logic        cpu_clk50,
    input  logic        cpu_rst,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [15:0] a_addr,
    input  logic [15:0] a_wdata,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [15:0] b_addr,
    input  logic [15:0] b_wdata,
    output logic        a_ack,
    output logic        b_ack,
    output logic [15:0] rdata,
    output logic        err,
    output logic        ram1_en,
    output logic        ram1_oe,
    output logic        ram1_we,
    output logic [15:0] ram1_addr,
    inout  wire  [15:0] ram1_data,
    output logic        uart_rdn,
    output logic        uart_wrn,
    input  logic        uart_tbre,
    input  logic        uart_tsre,
    input  logic        uart_data_ready
);

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_SRD1 = 4'd1,
        ST_SRD2 = 4'd2,
        ST_SWR1 = 4'd3,
        ST_SWR2 = 4'd4,
        ST_URD1 = 4'd5,
        ST_URD2 = 4'd6,
        ST_WTX  = 4'd7,
        ST_UWR1 = 4'd8,
        ST_UWR2 = 4'd9,
        ST_DONE = 4'd10
    } state_t;

    state_t      r_state;
    logic        r_sel_b;
    logic [15:0] r_wdata;
    logic        r_drive;
    logic [7:0]  r_cnt;
    logic        r_tbre_meta;
    logic        r_tbre_sync;
    logic        r_tsre_meta;
    logic        r_tsre_sync;
    logic        r_dr_meta;
    logic        r_dr_sync;

    logic        w_any_req;
    logic        w_req_we;
    logic [15:0] w_req_addr;
    logic [15:0] w_req_wdata;
    logic        w_tx_ready;
    logic [7:0]  w_cnt_next;

    // Port A has fixed priority whenever both request in the same idle cycle.
    assign w_any_req   = a_req | b_req;
    assign w_req_we    = a_req ? a_we    : b_we;
    assign w_req_addr  = a_req ? a_addr  : b_addr;
    assign w_req_wdata = a_req ? a_wdata : b_wdata;
    assign w_tx_ready  = r_tbre_sync & r_tsre_sync;
    assign w_cnt_next  = r_cnt + 8'd1;

    assign ram1_data = r_drive ? r_wdata : 16'hzzzz;

    always_ff @(posedge cpu_clk50 or negedge cpu_rst) begin
        if (!cpu_rst) begin
            r_state     <= ST_IDLE;
            r_sel_b     <= 1'b0;
            r_wdata     <= 16'h0000;
            r_drive     <= 1'b0;
            r_cnt       <= 8'd0;
            r_tbre_meta <= 1'b0;
            r_tbre_sync <= 1'b0;
            r_tsre_meta <= 1'b0;
            r_tsre_sync <= 1'b0;
            r_dr_meta   <= 1'b0;
            r_dr_sync   <= 1'b0;
            a_ack       <= 1'b0;
            b_ack       <= 1'b0;
            rdata       <= 16'h0000;
            err         <= 1'b0;
            ram1_en     <= 1'b1;
            ram1_oe     <= 1'b1;
            ram1_we     <= 1'b1;
            ram1_addr   <= 16'h0000;
            uart_rdn    <= 1'b1;
            uart_wrn    <= 1'b1;
        end else begin
            r_tbre_meta <= uart_tbre;
            r_tbre_sync <= r_tbre_meta;
            r_tsre_meta <= uart_tsre;
            r_tsre_sync <= r_tsre_meta;
            r_dr_meta   <= uart_data_ready;
            r_dr_sync   <= r_dr_meta;
            a_ack       <= 1'b0;
            b_ack       <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_sel_b   <= ~a_req;
                        ram1_addr <= w_req_addr;
                        r_wdata   <= w_req_wdata;
                        err       <= 1'b0;
                        if (w_req_addr == UART_DATA_ADDR) begin
                            if (w_req_we) begin
                                r_state <= ST_WTX;
                                r_cnt   <= 8'd0;
                            end else if (r_dr_sync) begin
                                r_state  <= ST_URD1;
                                uart_rdn <= 1'b0;
                            end else begin
                                r_state <= ST_DONE;
                                rdata   <= 16'h0000;
                                a_ack   <= a_req;
                                b_ack   <= ~a_req;
                            end
                        end else if (w_req_addr == UART_STAT_ADDR) begin
                            // Status writes complete with no bus activity.
                            if (!w_req_we) begin
                                rdata <= {14'b0, r_dr_sync, w_tx_ready};
                            end
                            r_state <= ST_DONE;
                            a_ack   <= a_req;
                            b_ack   <= ~a_req;
                        end else if (w_req_we) begin
                            r_state <= ST_SWR1;
                            ram1_en <= 1'b0;
                            ram1_we <= 1'b0;
                            r_drive <= 1'b1;
                        end else begin
                            r_state <= ST_SRD1;
                            ram1_en <= 1'b0;
                            ram1_oe <= 1'b0;
                        end
                    end
                end
                ST_SRD1: r_state <= ST_SRD2;
                ST_SRD2: begin
                    r_state <= ST_DONE;
                    rdata   <= ram1_data;
                    ram1_en <= 1'b1;
                    ram1_oe <= 1'b1;
                    a_ack   <= ~r_sel_b;
                    b_ack   <= r_sel_b;
                end
                ST_SWR1: begin
                    r_state <= ST_SWR2;
                    ram1_we <= 1'b1;
                end
                ST_SWR2: begin
                    r_state <= ST_DONE;
                    ram1_en <= 1'b1;
                    r_drive <= 1'b0;
                    a_ack   <= ~r_sel_b;
                    b_ack   <= r_sel_b;
                end
                ST_URD1: r_state <= ST_URD2;
                ST_URD2: begin
                    r_state  <= ST_DONE;
                    rdata    <= {8'h00, ram1_data[7:0]};
                    uart_rdn <= 1'b1;
                    a_ack    <= ~r_sel_b;
                    b_ack    <= r_sel_b;
                end
                ST_WTX: begin
                    // Ready wins over timeout when both land in the same cycle.
                    r_cnt <= w_cnt_next;
                    if (w_tx_ready) begin
                        r_state  <= ST_UWR1;
                        r_drive  <= 1'b1;
                        uart_wrn <= 1'b0;
                    end else if (w_cnt_next == TX_TIMEOUT) begin
                        r_state <= ST_DONE;
                        err     <= 1'b1;
                        a_ack   <= ~r_sel_b;
                        b_ack   <= r_sel_b;
                    end
                end
                ST_UWR1: begin
                    r_state  <= ST_UWR2;
                    uart_wrn <= 1'b1;
                end
                ST_UWR2: begin
                    r_state <= ST_DONE;
                    r_drive <= 1'b0;
                    a_ack   <= ~r_sel_b;
                    b_ack   <= r_sel_b;
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ram1_bus_ctrl.sv
// ============================================================================
// Module      : tb_ram1_bus_ctrl
// Description : Directed self-checking bench for ram1_bus_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram1_bus_ctrl;

    logic        cpu_clk50 = 1'b0;
    logic        cpu_rst   = 1'b1;
    logic        a_req = 1'b0, a_we = 1'b0;
    logic [15:0] a_addr = 16'h0, a_wdata = 16'h0;
    logic        b_req = 1'b0, b_we = 1'b0;
    logic [15:0] b_addr = 16'h0, b_wdata = 16'h0;
    logic        a_ack, b_ack, err;
    logic [15:0] rdata, ram1_addr;
    logic        ram1_en, ram1_oe, ram1_we, uart_rdn, uart_wrn;
    logic        uart_tbre = 1'b0, uart_tsre = 1'b0, uart_data_ready = 1'b0;
    wire  [15:0] ram1_data;

    // Bus model: SRAM answers reads, UART answers rdn, probe checks release.
    logic        probe = 1'b0;
    wire         w_tb_drv = probe | (~ram1_en & ~ram1_oe) | ~uart_rdn;
    wire  [15:0] w_tb_val = probe ? 16'h1E1E : (!uart_rdn ? 16'h345A : 16'hBEEF);
    assign ram1_data = w_tb_drv ? w_tb_val : 16'hzzzz;

    int total = 0;
    int bad   = 0;
    int n;
    bit saw;

    always #10 cpu_clk50 = ~cpu_clk50;

    ram1_bus_ctrl dut (
        .cpu_clk50       (cpu_clk50),
        .cpu_rst         (cpu_rst),
        .a_req           (a_req),
        .a_we            (a_we),
        .a_addr          (a_addr),
        .a_wdata         (a_wdata),
        .b_req           (b_req),
        .b_we            (b_we),
        .b_addr          (b_addr),
        .b_wdata         (b_wdata),
        .a_ack           (a_ack),
        .b_ack           (b_ack),
        .rdata           (rdata),
        .err             (err),
        .ram1_en         (ram1_en),
        .ram1_oe         (ram1_oe),
        .ram1_we         (ram1_we),
        .ram1_addr       (ram1_addr),
        .ram1_data       (ram1_data),
        .uart_rdn        (uart_rdn),
        .uart_wrn        (uart_wrn),
        .uart_tbre       (uart_tbre),
        .uart_tsre       (uart_tsre),
        .uart_data_ready (uart_data_ready)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge cpu_clk50);
        #1;
    endtask

    // A released bus lets the probe value through unaltered.
    task automatic chk_rel(input string tag);
        probe = 1'b1;
        #1;
        chk(tag, ram1_data, 16'h1E1E);
        probe = 1'b0;
        #1;
    endtask

    task automatic wait_ack(input bit want_b, input int limit, output int cnt, output bit wrn_seen);
        cnt = 0;
        wrn_seen = 1'b0;
        while (!(want_b ? b_ack : a_ack) && cnt < limit) begin
            tick();
            cnt++;
            if (!uart_wrn) wrn_seen = 1'b1;
        end
    endtask

    function automatic logic [15:0] strobes();
        return {11'b0, ram1_en, ram1_oe, ram1_we, uart_rdn, uart_wrn};
    endfunction

    function automatic logic [15:0] acks();
        return {14'b0, a_ack, b_ack};
    endfunction

    initial begin
        #5 cpu_rst = 1'b0;
        tick();
        tick();
        chk("rst_strobes", strobes(), 16'h001F);
        chk("rst_addr", ram1_addr, 16'h0000);
        chk("rst_rdata", rdata, 16'h0000);
        chk("rst_flags", {13'b0, a_ack, b_ack, err}, 16'h0000);
        chk_rel("rst_bus");
        cpu_rst = 1'b1;
        tick();

        // SRAM read on port A
        a_req = 1'b1; a_we = 1'b0; a_addr = 16'h1234;
        tick();
        a_req = 1'b0;
        chk("srd1_strobes", strobes(), 16'h0007);
        tick();
        chk("srd2_strobes", strobes(), 16'h0007);
        chk("srd2_noack", acks(), 16'h0000);
        tick();
        chk("srd_ack", acks(), 16'h0002);
        chk("srd_rdata", rdata, 16'hBEEF);
        chk("srd_done_strobes", strobes(), 16'h001F);
        tick();
        chk("srd_ack_once", acks(), 16'h0000);
        chk("idle_addr_hold", ram1_addr, 16'h1234);

        // Simultaneous SRAM writes: A first, B four cycles later
        a_req = 1'b1; a_we = 1'b1; a_addr = 16'h0010; a_wdata = 16'hAAAA;
        b_req = 1'b1; b_we = 1'b1; b_addr = 16'h0020; b_wdata = 16'h5555;
        tick();
        a_req = 1'b0; a_addr = 16'hFFFF; a_wdata = 16'h0000;
        chk("swr1_data", ram1_data, 16'hAAAA);
        chk("swr1_strobes", strobes(), 16'h000B);
        chk("swr1_addr", ram1_addr, 16'h0010);
        tick();
        chk("swr2_strobes", strobes(), 16'h000F);
        chk("swr2_data", ram1_data, 16'hAAAA);
        tick();
        chk("swr_a_ack", acks(), 16'h0002);
        chk_rel("swr_done_bus");
        tick();
        chk("swr_idle_addr", ram1_addr, 16'h0010);
        tick();
        b_req = 1'b0;
        chk("swr_b_data", ram1_data, 16'h5555);
        chk("swr_b_addr", ram1_addr, 16'h0020);
        tick();
        tick();
        chk("swr_b_ack", acks(), 16'h0001);
        tick();

        // UART write, transmitter busy 10 cycles then ready
        a_req = 1'b1; a_we = 1'b1; a_addr = 16'hBF00; a_wdata = 16'h0041;
        tick();
        a_req = 1'b0;
        chk("wtx_strobes", strobes(), 16'h001F);
        repeat (10) tick();
        chk("wtx_wrn_held", {15'b0, uart_wrn}, 16'h0001);
        uart_tbre = 1'b1; uart_tsre = 1'b1;
        n = 0;
        while (uart_wrn && n < 20) begin
            tick();
            n++;
        end
        chk("tx_ready_lat", 16'(n), 16'd3);
        chk("uwr1_data", ram1_data, 16'h0041);
        chk("uwr1_strobes", strobes(), 16'h001E);
        tick();
        chk("uwr2_strobes", strobes(), 16'h001F);
        tick();
        chk("uwr_ack", acks(), 16'h0002);
        chk("uwr_err", {15'b0, err}, 16'h0000);
        tick();

        // UART write timeout
        uart_tbre = 1'b0;
        repeat (3) tick();
        a_req = 1'b1; a_we = 1'b1; a_addr = 16'hBF00; a_wdata = 16'h0042;
        tick();
        a_req = 1'b0;
        wait_ack(1'b0, 400, n, saw);
        chk("tx_timeout_lat", 16'(n), 16'd255);
        chk("tx_timeout_err", {15'b0, err}, 16'h0001);
        chk("tx_timeout_nowrn", {15'b0, saw}, 16'h0000);
        tick();

        // Status read: data_ready=1, tbre=1, tsre=0
        uart_data_ready = 1'b1; uart_tbre = 1'b1; uart_tsre = 1'b0;
        repeat (3) tick();
        a_req = 1'b1; a_we = 1'b0; a_addr = 16'hBF01;
        tick();
        a_req = 1'b0;
        chk("stat_ack", acks(), 16'h0002);
        chk("stat_rdata", rdata, 16'h0002);
        tick();

        // UART data read with nothing received
        uart_data_ready = 1'b0;
        repeat (3) tick();
        b_req = 1'b1; b_we = 1'b0; b_addr = 16'hBF00;
        tick();
        b_req = 1'b0;
        chk("urd_nr_ack", acks(), 16'h0001);
        chk("urd_nr_rdata", rdata, 16'h0000);
        chk("urd_nr_rdn", {15'b0, uart_rdn}, 16'h0001);
        tick();

        // UART data read with a byte waiting
        uart_data_ready = 1'b1;
        repeat (3) tick();
        b_req = 1'b1; b_we = 1'b0; b_addr = 16'hBF00;
        tick();
        b_req = 1'b0;
        chk("urd1_strobes", strobes(), 16'h001D);
        tick();
        chk("urd2_strobes", strobes(), 16'h001D);
        tick();
        chk("urd_ack", acks(), 16'h0001);
        chk("urd_rdata", rdata, 16'h005A);
        chk("urd_done_rdn", {15'b0, uart_rdn}, 16'h0001);
        tick();

        // Write to status address: no bus activity
        a_req = 1'b1; a_we = 1'b1; a_addr = 16'hBF01; a_wdata = 16'h1234;
        tick();
        a_req = 1'b0;
        chk("statwr_ack", acks(), 16'h0002);
        chk("statwr_strobes", strobes(), 16'h001F);
        chk_rel("statwr_bus");
        tick();

        // Reset during SWR1 aborts asynchronously with no ack
        a_req = 1'b1; a_we = 1'b1; a_addr = 16'h0077; a_wdata = 16'hAAAA;
        tick();
        a_req = 1'b0;
        chk("abort_swr1_we", {15'b0, ram1_we}, 16'h0000);
        #2 cpu_rst = 1'b0;
        #1;
        chk("abort_we_async", {15'b0, ram1_we}, 16'h0001);
        chk_rel("abort_bus_async");
        saw = 1'b0;
        repeat (2) begin
            tick();
            if (a_ack || b_ack) saw = 1'b1;
        end
        cpu_rst = 1'b1;
        repeat (4) begin
            tick();
            if (a_ack || b_ack) saw = 1'b1;
        end
        chk("abort_no_ack", {15'b0, saw}, 16'h0000);
        chk("abort_addr_clr", ram1_addr, 16'h0000);
        chk("abort_strobes", strobes(), 16'h001F);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/ram1_bus_ctrl.md
RAM1_BUS_CTRL -- requirements
Module: ram1_bus_ctrl

Interface
REQ-001 SHALL have parameter UART_DATA_ADDR, default 16'hBF00, meaning the UART data register address.
REQ-002 SHALL have parameter UART_STAT_ADDR, default 16'hBF01, meaning the UART status register address.
REQ-003 SHALL have parameter TX_TIMEOUT, default 8'd255, meaning the maximum number of cycles spent waiting for the UART transmitter.
REQ-004 cpu_clk50  in  1  clock; all state changes on its rising edge.
REQ-005 cpu_rst  in  1  reset; asynchronous, active-low.
REQ-006 a_req, a_we  in  1,1  port A (CPU mem stage) request level and write flag.
REQ-007 a_addr, a_wdata  in  16,16  port A address and write data.
REQ-008 b_req, b_we, b_addr, b_wdata  in  1,1,16,16  port B (loader/debug) request, same meaning as port A.
REQ-009 a_ack, b_ack  out  1,1  one-cycle completion pulse per port.
REQ-010 rdata  out  16  read result, valid in the ack cycle.
REQ-011 err  out  1  valid with ack; 1 = UART transmit timed out.
REQ-012 ram1_en, ram1_oe, ram1_we  out  1 each  SRAM controls, active-low.
REQ-013 ram1_addr  out  16  SRAM address.
REQ-014 ram1_data  inout  16  shared SRAM/UART data bus.
REQ-015 uart_rdn, uart_wrn  out  1,1  UART strobes, active-low.
REQ-016 uart_tbre, uart_tsre, uart_data_ready  in  1 each  UART status inputs, synchronised with 2 flops before use.

Function
REQ-017 Arbitration SHALL occur only in IDLE: a_req wins over b_req; the grant is held until that port's ack.
REQ-018 Address, write flag and write data SHALL be latched at grant; later changes on the request inputs SHALL be ignored.
REQ-019 States SHALL be IDLE, SRD1, SRD2, SWR1, SWR2, URD1, URD2, WTX, UWR1, UWR2, DONE.
REQ-020 Decode SHALL be: addr==UART_DATA_ADDR -> UART path; addr==UART_STAT_ADDR -> status path; any other address -> SRAM path.
REQ-021 SRAM read SHALL run IDLE->SRD1->SRD2->DONE: en=0 and oe=0 in SRD1/SRD2; rdata sampled at the end of SRD2.
REQ-022 SRAM write SHALL run IDLE->SWR1->SWR2->DONE: data driven in SWR1/SWR2; we=0 in SWR1 only; en=0 throughout.
REQ-023 UART read SHALL behave as follows:
- if data_ready_sync=1: IDLE->URD1->URD2->DONE, with ram1_en=1, rdn=0 in URD1/URD2, rdata={8'h00, ram1_data[7:0]} sampled at the end of URD2;
- if data_ready_sync=0: go straight to DONE with rdata=0.
REQ-024 UART write SHALL run IDLE->WTX, wait until tbre_sync & tsre_sync, then ->UWR1->UWR2->DONE: ram1_en=1, data driven in UWR1/UWR2, wrn=0 in UWR1 only.
REQ-025 The WTX counter SHALL start at 0 on entry and increment each cycle; on reaching TX_TIMEOUT the FSM SHALL go to DONE with err=1 and no wrn pulse.
REQ-026 Status read SHALL go IDLE->DONE with rdata={14'b0, data_ready_sync, tbre_sync & tsre_sync}.
REQ-027 A write to UART_STAT_ADDR SHALL go IDLE->DONE with no bus activity.
REQ-028 In DONE, the granted port's ack SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE; a still-high request is treated as a new request.
REQ-029 ram1_data SHALL be high-Z in every state except SWR1, SWR2, UWR1, UWR2.
REQ-030 ram1_we=0 and uart_wrn=0 SHALL never both be asserted; oe=0 and a driven bus SHALL never coincide.
REQ-031 Idle outputs SHALL be en=oe=we=rdn=wrn=1 and ram1_addr = last latched address.
REQ-032 Latency SHALL be, from grant to ack cycle:
- SRAM read and SRAM write: 3 cycles;
- UART read when ready: 3 cycles;
- status read: 1 cycle;
- UART write: WTX cycles + 3.

Reset
REQ-033 While cpu_rst=0: state=IDLE, all strobes=1, ram1_data=Z, ram1_addr=0, rdata=0, acks=0, err=0, counter=0, synchronisers=0.
REQ-034 Reset mid-transaction SHALL abort immediately, with no ack.

Verification
REQ-035 Port A reads SRAM at 0x1234 with the model returning 0xBEEF -> en/oe low 2 cycles, a_ack pulses 3 cycles after grant, rdata=0xBEEF.
REQ-036 a_req and b_req rise in the same cycle, both SRAM writes -> A is served first; b_ack follows A's ack by 4 cycles; the bus shows A's data, then B's.
REQ-037 UART write of 0x0041 with tbre=tsre=0 for 10 cycles, then 1 -> wrn low one cycle with ram1_data[7:0]=0x41, err=0.
REQ-038 UART write with tbre held 0 -> ack arrives TX_TIMEOUT cycles after WTX entry, err=1, no wrn pulse.
REQ-039 Status read with data_ready=1, tbre=1, tsre=0 -> rdata=0x0002; UART data read with data_ready=0 -> rdata=0, rdn stays 1.
REQ-040 cpu_rst pulsed low during SWR1 -> we returns to 1 and the bus returns to Z asynchronously, with no ack.
